mcycle_ctrl: RTL and testbench
==============================

# mcycle_ctrl

Sequencer for the iterative multiply/divide unit in the Execute stage of the 5-stage ARM pipeline. It accepts a condition-passed MUL/DIV from Execute and drives the operand load and per-iteration step strobes of the shift-add/shift-subtract datapath. It raises a stall request that the pipeline ORs into StallF/StallD/StallE while it runs, and pulses Done when the result is valid. This is the multi-cycle stall source that the single-cycle LDR hazard logic does not cover.

## Interface
Parameters:
- WIDTH, 32, operand width; also the counter range bound
- MUL_ITERS, 32, step cycles for multiply (1..WIDTH)
- DIV_ITERS, 32, step cycles for divide (1..WIDTH)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high; forces IDLE
- Start  in  1  Execute holds a valid, condition-passed MUL/DIV (already ANDed with CondEx)
- MCycleOp  in  1  0 = multiply, 1 = divide; sampled only when the operation is accepted
- Cancel  in  1  abort the current operation (exception/flush of Execute)
- Load  out  1  latch operands into the datapath registers; combinational
- Step  out  1  perform one iteration this cycle
- Busy  out  1  stall request: StallF, StallD and StallE held, bubble into M; combinational
- Done  out  1  result valid this cycle; one-cycle pulse
- Count  out  $clog2(WIDTH+1)  iterations completed in the current operation
- OpLatched  out  1  operation type captured at Load

## Operation
- States: IDLE, RUN, DONE. Encoded in 2 bits; the encoding is defined in the package.
- IDLE with Start=1 and Cancel=0:
  - Load=1 and Busy=1 in the same cycle.
  - Capture MCycleOp into OpLatched, set Count=0 and the iteration limit N (MUL_ITERS or DIV_ITERS).
  - Next state is RUN.
- IDLE otherwise: Load=Step=Busy=Done=0; Count and OpLatched hold.
- RUN:
  - Step=1 and Busy=1.
  - Count increments each cycle.
  - When Count==N-1 the state moves to DONE, and Count reaches N on that edge.
- DONE:
  - Done=1 and Busy=0, so the instruction leaves Execute at the end of this cycle.
  - Next state is always IDLE, even if Start=1. A Start seen in IDLE always belongs to a new instruction.
- Cancel in any state: next state is IDLE; Load, Step and Done are forced to 0 in that cycle; Busy=0. Cancel takes priority over Start.
- Start dropping in RUN is ignored. Only Cancel aborts.
- The Count width must hold WIDTH without overflow. N-1 is compared at the Count width.

## Timing
- Reset values: state=IDLE, Count=0, OpLatched=0. Load, Step, Busy and Done are all 0 during and after Reset.
- With Start first seen in IDLE at cycle T:
  - Load at T.
  - Step at T+1..T+N.
  - Done at T+N+1.
  - Busy high for T..T+N, which is N+1 stall cycles.
  - Execute occupancy is N+2 cycles.
- Back-to-back MUL/DIV: the second instruction enters Execute at T+N+2 in IDLE, and its Load occurs that same cycle. There are no dead cycles between operations.
- N=1: Load at T, a single Step at T+1, Done at T+2.
- Reset asserted mid-RUN: state is IDLE immediately (asynchronous), with no Done pulse. Operation resumes on the first edge after deassertion.
- Busy must not depend combinationally on the hazard unit's outputs, so no combinational loop forms through Stall/Flush.

## Structure
- Package mcycle_pkg holds:
  - state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - op codes OP_MUL=1'b0, OP_DIV=1'b1
- Single flat module: one state register, one counter, combinational output decode. No sub-module is warranted.
- Top-level integration:
  - StallF/StallD = LDRstall | Busy
  - StallE = Busy
  - FlushM-bubble = Busy

## Test plan
- Reset, then MUL with default parameters: Start=1, MCycleOp=0 at T → Load@T, Step@T+1..T+32, Done@T+33, Busy high 33 cycles, Count=32 at Done.
- DIV with DIV_ITERS=4: Start at T → Step@T+1..T+4, Done@T+5, OpLatched=1, Busy low at T+5.
- Back-to-back MUL then DIV with Start held high across the boundary → Done@T+33, second Load@T+34, no extra IDLE cycle, no double Done.
- Cancel at T+10 of a MUL → IDLE at T+11, no Done ever, Busy=0 in the Cancel cycle; a Start with Cancel both high in IDLE produces no Load.
- Reset asserted at T+5 of a DIV → state=IDLE, Count=0 and all outputs 0 before the next edge; Start after release → Load on the first post-reset edge cycle.
- MUL_ITERS=1 → Load@T, single Step@T+1, Done@T+2.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package mcycle_pkg;

    // Sequencer state encoding (2 bits).
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mcycle_state_t;

    // Operation type as carried on MCycleOp / OpLatched.
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mcycle_ctrl.sv
// Sequencer for the iterative MUL/DIV datapath in Execute. It issues Load
// when an operation is accepted, then one Step per iteration, and then a
// single Done pulse. Busy is the stall request the pipeline ORs into
// StallF/StallD/StallE. Busy is decoded only from local state and the
// Start/Cancel/Reset inputs, so it never forms a loop through the hazard unit.
module mcycle_ctrl
    import mcycle_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_ITERS = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic                         MCycleOp,
    input  logic                         Cancel,
    output logic                         Load,
    output logic                         Step,
    output logic                         Busy,
    output logic                         Done,
    output logic [$clog2(WIDTH+1)-1:0]   Count,
    output logic                         OpLatched
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_N = CW'(MUL_ITERS);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_ITERS);

    mcycle_state_t   state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   lim_q,   lim_d;
    logic            op_q,    op_d;

    // State, iteration counter, limit and latched op; async reset to IDLE.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            lim_q   <= '0;
            op_q    <= OP_MUL;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lim_q   <= lim_d;
            op_q    <= op_d;
        end
    end

    // Next-state and output decode. Reset holds every strobe low even while
    // Start is high; Cancel beats Start and drops the operation immediately.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lim_d   = lim_q;
        op_d    = op_q;
        Load    = 1'b0;
        Step    = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        if (Reset) begin
            state_d = IDLE;
        end else if (Cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        Load    = 1'b1;
                        Busy    = 1'b1;
                        op_d    = MCycleOp;
                        count_d = '0;
                        lim_d   = (MCycleOp == OP_DIV) ? DIV_N : MUL_N;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    Step    = 1'b1;
                    Busy    = 1'b1;
                    count_d = count_q + CW'(1);
                    // Last iteration: Count lands on N as we enter DONE.
                    if (count_q == lim_q - CW'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // Busy drops so the instruction leaves Execute; a Start
                    // seen now belongs to the same instruction and is ignored.
                    Done    = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign Count     = count_q;
    assign OpLatched = op_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Bench for mcycle_ctrl: two instances with different iteration limits share
// one stimulus stream; a per-cycle expected record is queued for each
// instance when inputs are driven and compared on the falling edge.
module tb_mcycle_ctrl;

    localparam int WIDTH = 32;
    localparam int CW    = $clog2(WIDTH + 1);

    // Instance 0: MUL=32, DIV=4. Instance 1: MUL=1, DIV=32.
    localparam int MUL_N0 = 32;
    localparam int DIV_N0 = 4;
    localparam int MUL_N1 = 1;
    localparam int DIV_N1 = 32;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    logic Start = 1'b0;
    logic MCycleOp = 1'b0;
    logic Cancel = 1'b0;

    logic          load0, step0, busy0, done0, op0;
    logic [CW-1:0] cnt0;
    logic          load1, step1, busy1, done1, op1;
    logic [CW-1:0] cnt1;

    always #5 CLK = ~CLK;

    mcycle_ctrl #(.WIDTH(WIDTH), .MUL_ITERS(MUL_N0), .DIV_ITERS(DIV_N0)) dut0 (
        .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp), .Cancel(Cancel),
        .Load(load0), .Step(step0), .Busy(busy0), .Done(done0),
        .Count(cnt0), .OpLatched(op0)
    );

    mcycle_ctrl #(.WIDTH(WIDTH), .MUL_ITERS(MUL_N1), .DIV_ITERS(DIV_N1)) dut1 (
        .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp), .Cancel(Cancel),
        .Load(load1), .Step(step1), .Busy(busy1), .Done(done1),
        .Count(cnt1), .OpLatched(op1)
    );

    typedef struct {
        logic load;
        logic step;
        logic busy;
        logic done;
        int   count;
        logic op;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model per instance: ph = 0 idle, 1..N step number, N+1 done.
    int   ph[2];
    int   nn[2];
    int   mc[2];
    logic mo[2];
    int   mul_n[2];
    int   div_n[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic model(input int d);
        exp_t e;
        e = '{load: 1'b0, step: 1'b0, busy: 1'b0, done: 1'b0, count: 0, op: 1'b0};
        if (Reset) begin
            ph[d] = 0;
            mc[d] = 0;
            mo[d] = 1'b0;
        end else if (Cancel) begin
            e.count = mc[d];
            e.op    = mo[d];
            ph[d]   = 0;
        end else if (ph[d] == 0) begin
            e.count = mc[d];
            e.op    = mo[d];
            if (Start) begin
                e.load = 1'b1;
                e.busy = 1'b1;
                mo[d]  = MCycleOp;
                nn[d]  = MCycleOp ? div_n[d] : mul_n[d];
                mc[d]  = 0;
                ph[d]  = 1;
            end
        end else if (ph[d] <= nn[d]) begin
            e.step  = 1'b1;
            e.busy  = 1'b1;
            e.count = ph[d] - 1;
            e.op    = mo[d];
            mc[d]   = ph[d];
            ph[d]   = ph[d] + 1;
        end else begin
            e.done  = 1'b1;
            e.count = mc[d];
            e.op    = mo[d];
            ph[d]   = 0;
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic compare(input int d, input logic l, input logic s, input logic b,
                           input logic dn, input logic [CW-1:0] c, input logic o);
        exp_t e;
        string p;
        p = $sformatf("d%0d@%0t", d, $time);
        if (d == 0) begin
            chk({p, ".sb_depth"}, q0.size(), 1);
            if (q0.size() == 0) return;
            e = q0.pop_front();
        end else begin
            chk({p, ".sb_depth"}, q1.size(), 1);
            if (q1.size() == 0) return;
            e = q1.pop_front();
        end
        chk({p, ".Load"},      l, e.load);
        chk({p, ".Step"},      s, e.step);
        chk({p, ".Busy"},      b, e.busy);
        chk({p, ".Done"},      dn, e.done);
        chk({p, ".Count"},     c, e.count);
        chk({p, ".OpLatched"}, o, e.op);
    endtask

    // One clock cycle: drive inputs just after the rising edge, queue the
    // expected outputs, compare on the falling edge.
    task automatic cyc(input logic r, input logic st, input logic op, input logic cn);
        @(posedge CLK);
        #1;
        Reset    = r;
        Start    = st;
        MCycleOp = op;
        Cancel   = cn;
        model(0);
        model(1);
        @(negedge CLK);
        compare(0, load0, step0, busy0, done0, cnt0, op0);
        compare(1, load1, step1, busy1, done1, cnt1, op1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        mul_n[0] = MUL_N0; div_n[0] = DIV_N0;
        mul_n[1] = MUL_N1; div_n[1] = DIV_N1;
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; nn[d] = 1; mc[d] = 0; mo[d] = 1'b0;
        end

        // Reset, including Start high while Reset is held (no Load allowed).
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // Single MUL (32 steps on dut0, 1 step on dut1).
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(36);

        // Single DIV (4 steps on dut0, 32 on dut1).
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(36);

        // Back-to-back: Start held high, MUL accepted first then DIV.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(36);

        // Cancel at T+10 of a MUL, then Start with Cancel in IDLE.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(9);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle(36);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Reset at T+5 of a DIV, then Start on the first cycle after release.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(4);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(36);

        // Random traffic with sparse Cancel and Reset.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 29) == 0));
        end
        idle(36);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
